// File: rtl/amo_rmw_seq_pkg.sv
// Shared AMO definitions: funct5 encodings, sequencer state type and fault codes.
// Used by the uncached RMW sequencer and by the cache AMO path.
package amo_rmw_seq_pkg;

  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ACCESS   = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    RESP    = 3'd4
  } amostate_t;

  function automatic logic amo_legal(input logic [4:0] funct5);
    case (funct5)
      AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: amo_legal = 1'b1;
      default:                              amo_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/amo_rmw_seq_if.sv
// AMO request/response and bus signals of the uncached RMW sequencer.
// slave = sequencer view, master = LSU/bus environment view.
interface amo_rmw_seq_if #(
  parameter int XLEN    = 64,
  parameter int PA_BITS = 56
);
  logic               AmoReqValid;
  logic               AmoReqReady;
  logic [4:0]         AmoFunct5;
  logic               AmoDouble;
  logic [PA_BITS-1:0] AmoAdr;
  logic [XLEN-1:0]    AmoSrc;
  logic               BusRead;
  logic               BusWrite;
  logic [PA_BITS-1:0] BusAdr;
  logic [XLEN/8-1:0]  BusByteEn;
  logic [XLEN-1:0]    BusWData;
  logic               BusReady;
  logic               BusRValid;
  logic [XLEN-1:0]    BusRData;
  logic               BusErr;
  logic               AmoRespValid;
  logic [XLEN-1:0]    AmoResult;
  logic [1:0]         AmoFault;

  modport slave (
    input  AmoReqValid, AmoFunct5, AmoDouble, AmoAdr, AmoSrc,
           BusReady, BusRValid, BusRData, BusErr,
    output AmoReqReady, BusRead, BusWrite, BusAdr, BusByteEn, BusWData,
           AmoRespValid, AmoResult, AmoFault
  );

  modport master (
    output AmoReqValid, AmoFunct5, AmoDouble, AmoAdr, AmoSrc,
           BusReady, BusRValid, BusRData, BusErr,
    input  AmoReqReady, BusRead, BusWrite, BusAdr, BusByteEn, BusWData,
           AmoRespValid, AmoResult, AmoFault
  );
endinterface

// File: rtl/amo_rmw_seq_amoalu.sv
// Combinational AMO ALU: new memory value from old value a and operand b.
// For word ops only bits [31:0] of the result are meaningful.
module amo_rmw_seq_amoalu
  import amo_rmw_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      funct5,
  input  logic            width,
  output logic [XLEN-1:0] y
);

  logic lt_s;
  logic lt_u;

  // compare at the operation width
  always_comb begin
    if (width) begin
      lt_s = $signed(a) < $signed(b);
      lt_u = a < b;
    end else begin
      lt_s = $signed(a[31:0]) < $signed(b[31:0]);
      lt_u = a[31:0] < b[31:0];
    end
  end

  // operation select
  always_comb begin
    y = a;
    case (funct5)
      AMO_SWAP: y = b;
      AMO_ADD:  y = a + b;
      AMO_XOR:  y = a ^ b;
      AMO_AND:  y = a & b;
      AMO_OR:   y = a | b;
      AMO_MIN:  y = lt_s ? a : b;
      AMO_MAX:  y = lt_s ? b : a;
      AMO_MINU: y = lt_u ? a : b;
      AMO_MAXU: y = lt_u ? b : a;
      default:  y = a;
    endcase
  end

endmodule

// File: rtl/amo_rmw_seq.sv
// Read-modify-write sequencer for AMOs to uncacheable space: bus read, ALU update,
// posted bus write, then a one-cycle response carrying the original memory value.
module amo_rmw_seq
  import amo_rmw_seq_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int PA_BITS = 56
) (
  input logic         clk,
  input logic         reset,
  amo_rmw_seq_if.slave amo
);

  localparam int   NB   = XLEN / 8;
  localparam int   OFS  = $clog2(NB);
  localparam logic IS64 = (XLEN == 64);

  amostate_t state, state_next;

  logic [4:0]         funct5_r;
  logic               dbl_r;
  logic               lane_r;
  logic [PA_BITS-1:OFS] adr_r;
  logic [XLEN-1:0]    src_r;
  logic [XLEN-1:0]    a_r;

  logic               dbl_in;
  logic               misalign_in;
  logic [1:0]         fault_next;
  logic [PA_BITS-1:OFS] adr_cur;
  logic [31:0]        rd_word;
  logic [XLEN-1:0]    alu_a;
  logic [XLEN-1:0]    alu_b;
  logic [XLEN-1:0]    alu_y;
  logic [XLEN-1:0]    wdata_next;
  logic [NB-1:0]      be_next;

  amo_rmw_seq_amoalu #(.XLEN(XLEN)) u_amoalu (
    .a      (alu_a),
    .b      (alu_b),
    .funct5 (funct5_r),
    .width  (dbl_r),
    .y      (alu_y)
  );

  // operand lane selection and write data/byte-enable formation
  always_comb begin
    dbl_in      = IS64 & amo.AmoDouble;
    misalign_in = dbl_in ? (amo.AmoAdr[2:0] != 3'b000) : (amo.AmoAdr[1:0] != 2'b00);
    adr_cur     = (state == IDLE) ? amo.AmoAdr[PA_BITS-1:OFS] : adr_r;
    rd_word     = lane_r ? amo.BusRData[XLEN-1 -: 32] : amo.BusRData[31:0];
    alu_a       = dbl_r ? amo.BusRData : XLEN'(signed'(rd_word));
    alu_b       = dbl_r ? src_r : XLEN'(signed'(src_r[31:0]));
    if (state == RD_WAIT) begin
      wdata_next = dbl_r ? alu_y : {(XLEN/32){alu_y[31:0]}};
      be_next    = dbl_r ? {NB{1'b1}} : (lane_r ? NB'(8'hF0) : NB'(8'h0F));
    end else begin
      wdata_next = amo.BusWData;
      be_next    = amo.BusByteEn;
    end
  end

  // next-state and fault selection
  always_comb begin
    state_next = state;
    fault_next = FAULT_NONE;
    case (state)
      IDLE: begin
        if (amo.AmoReqValid) begin
          if (!amo_legal(amo.AmoFunct5)) begin
            state_next = RESP;
            fault_next = FAULT_ILLEGAL;
          end else if (misalign_in) begin
            state_next = RESP;
            fault_next = FAULT_MISALIGN;
          end else begin
            state_next = RD_REQ;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RD_REQ: begin
        if (amo.BusReady) state_next = RD_WAIT;
        else              state_next = RD_REQ;
      end
      RD_WAIT: begin
        if (amo.BusRValid && amo.BusErr) begin
          state_next = RESP;
          fault_next = FAULT_ACCESS;
        end else if (amo.BusRValid) begin
          state_next = WR_REQ;
        end else begin
          state_next = RD_WAIT;
        end
      end
      WR_REQ: begin
        if (amo.BusReady) state_next = RESP;
        else              state_next = WR_REQ;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // state, captured request and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      funct5_r         <= 5'b00000;
      dbl_r            <= 1'b0;
      lane_r           <= 1'b0;
      adr_r            <= '0;
      src_r            <= '0;
      a_r              <= '0;
      amo.AmoReqReady  <= 1'b1;
      amo.BusRead      <= 1'b0;
      amo.BusWrite     <= 1'b0;
      amo.BusAdr       <= '0;
      amo.BusByteEn    <= '0;
      amo.BusWData     <= '0;
      amo.AmoRespValid <= 1'b0;
      amo.AmoResult    <= '0;
      amo.AmoFault     <= FAULT_NONE;
    end else begin
      state <= state_next;
      if (state == IDLE && amo.AmoReqValid) begin
        funct5_r <= amo.AmoFunct5;
        dbl_r    <= dbl_in;
        lane_r   <= IS64 & amo.AmoAdr[2];
        adr_r    <= amo.AmoAdr[PA_BITS-1:OFS];
        src_r    <= amo.AmoSrc;
      end
      if (state == RD_WAIT && amo.BusRValid && !amo.BusErr) begin
        a_r <= alu_a;
      end
      amo.AmoReqReady  <= (state_next == IDLE);
      amo.BusRead      <= (state_next == RD_REQ);
      amo.BusWrite     <= (state_next == WR_REQ);
      amo.BusAdr       <= (state_next == RD_REQ || state_next == RD_WAIT || state_next == WR_REQ)
                          ? {adr_cur, {OFS{1'b0}}} : '0;
      amo.BusWData     <= (state_next == WR_REQ) ? wdata_next : '0;
      amo.BusByteEn    <= (state_next == WR_REQ) ? be_next : '0;
      amo.AmoRespValid <= (state_next == RESP);
      amo.AmoFault     <= (state_next == RESP) ? fault_next : FAULT_NONE;
      amo.AmoResult    <= (state_next == RESP && fault_next == FAULT_NONE && state == WR_REQ)
                          ? a_r : '0;
    end
  end

endmodule

// File: tb/tb_amo_rmw_seq.sv
// Directed self-checking bench for amo_rmw_seq (XLEN=64) with a cycle-stepped bus responder.
module tb_amo_rmw_seq;

  localparam int XLEN    = 64;
  localparam int PA_BITS = 56;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  amo_rmw_seq_if #(.XLEN(XLEN), .PA_BITS(PA_BITS)) bus ();

  amo_rmw_seq #(.XLEN(XLEN), .PA_BITS(PA_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .amo   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic               obs_read, obs_write, obs_stable;
  logic [63:0]        obs_wdata, obs_result;
  logic [7:0]         obs_be;
  logic [PA_BITS-1:0] obs_adr;
  logic [1:0]         obs_fault;
  int                 obs_cyc;
  logic               resp_seen;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one AMO and plays the bus: read/write accepted after 'stall' cycles,
  // read data returned the cycle after read acceptance.
  task automatic run_amo(input string tag, input logic [4:0] f5, input logic dbl,
                         input logic [PA_BITS-1:0] adr, input logic [63:0] src,
                         input logic [63:0] rdata, input logic err, input int stall);
    bit rv_next;
    bit done;
    int rd_cnt;
    int wr_cnt;
    obs_read = 1'b0; obs_write = 1'b0; obs_stable = 1'b1;
    obs_wdata = '0; obs_be = '0; obs_adr = '0; obs_result = '0; obs_fault = 2'b00;
    obs_cyc = -1;
    rv_next = 1'b0; done = 1'b0; rd_cnt = 0; wr_cnt = 0;
    check_eq({tag, "_ready"}, {63'd0, bus.AmoReqReady}, 64'd1);
    bus.AmoReqValid = 1'b1;
    bus.AmoFunct5   = f5;
    bus.AmoDouble   = dbl;
    bus.AmoAdr      = adr;
    bus.AmoSrc      = src;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      bus.AmoReqValid = 1'b0;
      bus.BusReady    = 1'b0;
      bus.BusRValid   = 1'b0;
      bus.BusErr      = 1'b0;
      bus.BusRData    = '0;
      if (rv_next) begin
        bus.BusRValid = 1'b1;
        bus.BusRData  = rdata;
        bus.BusErr    = err;
        rv_next       = 1'b0;
      end
      if (bus.BusRead) begin
        obs_read = 1'b1;
        if (rd_cnt == 0) obs_adr = bus.BusAdr;
        else if (bus.BusAdr !== obs_adr) obs_stable = 1'b0;
        if (rd_cnt >= stall) begin
          bus.BusReady = 1'b1;
          rv_next      = 1'b1;
        end
        rd_cnt++;
      end
      if (bus.BusWrite) begin
        obs_write = 1'b1;
        if (wr_cnt == 0) begin
          obs_wdata = bus.BusWData;
          obs_be    = bus.BusByteEn;
          if (bus.BusAdr !== obs_adr) obs_stable = 1'b0;
        end else if (bus.BusWData !== obs_wdata || bus.BusByteEn !== obs_be ||
                     bus.BusAdr !== obs_adr) begin
          obs_stable = 1'b0;
        end
        if (wr_cnt >= stall) bus.BusReady = 1'b1;
        wr_cnt++;
      end
      if (bus.AmoRespValid) begin
        obs_cyc    = c;
        obs_result = bus.AmoResult;
        obs_fault  = bus.AmoFault;
        done       = 1'b1;
      end
    end
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, {63'd0, bus.AmoRespValid}, 64'd0);
  endtask

  task automatic expect_all(input string tag, input logic e_read, input logic e_write,
                            input logic [63:0] e_wdata, input logic [7:0] e_be,
                            input logic [PA_BITS-1:0] e_adr, input logic [63:0] e_result,
                            input logic [1:0] e_fault, input int e_cyc);
    check_eq({tag, "_read"},   {63'd0, obs_read}, {63'd0, e_read});
    check_eq({tag, "_write"},  {63'd0, obs_write}, {63'd0, e_write});
    check_eq({tag, "_wdata"},  obs_wdata, e_wdata);
    check_eq({tag, "_be"},     {56'd0, obs_be}, {56'd0, e_be});
    check_eq({tag, "_adr"},    64'(obs_adr), 64'(e_adr));
    check_eq({tag, "_result"}, obs_result, e_result);
    check_eq({tag, "_fault"},  {62'd0, obs_fault}, {62'd0, e_fault});
    check_eq({tag, "_cycle"},  64'(obs_cyc), 64'(e_cyc));
    check_eq({tag, "_stable"}, {63'd0, obs_stable}, 64'd1);
  endtask

  initial begin
    bus.AmoReqValid = 1'b0; bus.AmoFunct5 = 5'd0; bus.AmoDouble = 1'b0;
    bus.AmoAdr = '0; bus.AmoSrc = '0;
    bus.BusReady = 1'b0; bus.BusRValid = 1'b0; bus.BusRData = '0; bus.BusErr = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check_eq("rst_ready",  {63'd0, bus.AmoReqReady}, 64'd1);
    check_eq("rst_read",   {63'd0, bus.BusRead}, 64'd0);
    check_eq("rst_write",  {63'd0, bus.BusWrite}, 64'd0);
    check_eq("rst_resp",   {63'd0, bus.AmoRespValid}, 64'd0);
    check_eq("rst_result", bus.AmoResult, 64'd0);
    check_eq("rst_be",     {56'd0, bus.BusByteEn}, 64'd0);

    run_amo("add_d", 5'b00000, 1'b1, 56'h8000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 0);
    expect_all("add_d", 1'b1, 1'b1, 64'h8000_0000_0000_0000, 8'hFF, 56'h8000_0000,
               64'h7FFF_FFFF_FFFF_FFFF, 2'b00, 4);

    run_amo("min_w", 5'b10000, 1'b0, 56'h8000_0004, 64'h0000_0000_FFFF_FFFF,
            64'h0000_0005_DEAD_BEEF, 1'b0, 0);
    expect_all("min_w", 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 56'h8000_0000,
               64'h0000_0000_0000_0005, 2'b00, 4);

    run_amo("maxu_w", 5'b11100, 1'b0, 56'h8000_0000, 64'h1, 64'h1234_5678_8000_0000, 1'b0, 0);
    expect_all("maxu_w", 1'b1, 1'b1, 64'h8000_0000_8000_0000, 8'h0F, 56'h8000_0000,
               64'hFFFF_FFFF_8000_0000, 2'b00, 4);

    run_amo("and_w_hi", 5'b01100, 1'b0, 56'h8000_000C, 64'hFFFF_FFFF_0FF0_FFFF,
            64'hF0F0_1234_0000_0000, 1'b0, 0);
    expect_all("and_w_hi", 1'b1, 1'b1, 64'h00F0_1234_00F0_1234, 8'hF0, 56'h8000_0008,
               64'hFFFF_FFFF_F0F0_1234, 2'b00, 4);

    run_amo("max_d", 5'b10100, 1'b1, 56'h8000_0008, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 0);
    expect_all("max_d", 1'b1, 1'b1, 64'h0000_0000_0000_0001, 8'hFF, 56'h8000_0008,
               64'h8000_0000_0000_0000, 2'b00, 4);

    run_amo("mis_w", 5'b00001, 1'b0, 56'h8000_0002, 64'h5, 64'h0, 1'b0, 0);
    expect_all("mis_w", 1'b0, 1'b0, 64'h0, 8'h00, 56'h0, 64'h0, 2'b01, 1);

    run_amo("mis_d", 5'b00000, 1'b1, 56'h8000_0004, 64'h5, 64'h0, 1'b0, 0);
    expect_all("mis_d", 1'b0, 1'b0, 64'h0, 8'h00, 56'h0, 64'h0, 2'b01, 1);

    run_amo("illegal", 5'b00010, 1'b0, 56'h8000_0000, 64'h5, 64'h0, 1'b0, 0);
    expect_all("illegal", 1'b0, 1'b0, 64'h0, 8'h00, 56'h0, 64'h0, 2'b11, 1);

    run_amo("bus_err", 5'b00000, 1'b0, 56'h8000_0000, 64'h5, 64'h1111_2222_3333_4444, 1'b1, 0);
    expect_all("bus_err", 1'b1, 1'b0, 64'h0, 8'h00, 56'h8000_0000, 64'h0, 2'b10, 3);

    run_amo("xor_stall", 5'b00100, 1'b1, 56'h8000_0010, 64'hFFFF_0000_FFFF_0000,
            64'hF0F0_F0F0_0F0F_0F0F, 1'b0, 3);
    expect_all("xor_stall", 1'b1, 1'b1, 64'h0F0F_F0F0_F0F0_0F0F, 8'hFF, 56'h8000_0010,
               64'hF0F0_F0F0_0F0F_0F0F, 2'b00, 10);

    // reset while waiting for read data abandons the request
    bus.AmoReqValid = 1'b1; bus.AmoFunct5 = 5'b00000; bus.AmoDouble = 1'b1;
    bus.AmoAdr = 56'h8000_0020; bus.AmoSrc = 64'h7;
    @(posedge clk); #1;
    bus.AmoReqValid = 1'b0;
    check_eq("rst_mid_rdreq", {63'd0, bus.BusRead}, 64'd1);
    bus.BusReady = 1'b1;
    @(posedge clk); #1;
    bus.BusReady = 1'b0;
    check_eq("rst_mid_wait_ready", {63'd0, bus.AmoReqReady}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rst_mid_read",  {63'd0, bus.BusRead}, 64'd0);
    check_eq("rst_mid_ready", {63'd0, bus.AmoReqReady}, 64'd1);
    check_eq("rst_mid_adr",   64'(bus.BusAdr), 64'd0);
    resp_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.AmoRespValid) resp_seen = 1'b1;
    end
    check_eq("rst_mid_noresp", {63'd0, resp_seen}, 64'd0);

    run_amo("swap_after_rst", 5'b00001, 1'b0, 56'h8000_0004, 64'hAAAA_AAAA_1234_5678,
            64'h8765_4321_0000_0000, 1'b0, 0);
    expect_all("swap_after_rst", 1'b1, 1'b1, 64'h1234_5678_1234_5678, 8'hF0, 56'h8000_0000,
               64'hFFFF_FFFF_8765_4321, 2'b00, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/amo_rmw_seq.md
Name: amo_rmw_seq

Overview:
- Read-modify-write sequencer for atomic memory operations (AMOs) that target uncacheable/bus space, where the cache cannot perform the update in place.
- Sits in the LSU beside the LR/SC reservation tracker.
- Accepts one AMO at a time, issues a bus read, computes the new value, issues a bus write, and returns the original memory value for the register-file writeback.
- The pipeline holds the instruction in M until the response arrives.

Parameters:
- P, default cvw_t default config: supplies XLEN (32 or 64) and PA_BITS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- AmoReqValid  in  1  AMO request present
- AmoReqReady  out  1  sequencer can accept a request
- AmoFunct5  in  5  AMO funct5 encoding
- AmoDouble  in  1  0 = .W, 1 = .D (ignored and treated as 0 when XLEN=32)
- AmoAdr  in  PA_BITS  physical address
- AmoSrc  in  XLEN  rs2 operand
- BusRead  out  1  read request
- BusWrite  out  1  write request
- BusAdr  out  PA_BITS  request address (XLEN/8-aligned)
- BusByteEn  out  XLEN/8  write byte enables
- BusWData  out  XLEN  write data
- BusReady  in  1  bus accepts the current request
- BusRValid  in  1  read data valid
- BusRData  in  XLEN  read data
- BusErr  in  1  read error, qualified by BusRValid
- AmoRespValid  out  1  one-cycle response pulse
- AmoResult  out  XLEN  original memory value; .W results sign-extended
- AmoFault  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct5; valid with AmoRespValid

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0 except AmoReqReady=1.
  - Reset mid-operation abandons the request: no response, and BusRead/BusWrite drop the next cycle.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- IDLE:
  - AmoReqReady=1.
  - On AmoReqValid, register funct5, width, address and AmoSrc.
  - If funct5 is illegal or the address is misaligned (.W: Adr[1:0]!=0; .D: Adr[2:0]!=0), go to RESP with the fault set and no bus activity.
  - Otherwise go to RD_REQ.
- RD_REQ: BusRead=1 and BusAdr held stable until BusReady=1, then go to RD_WAIT.
- RD_WAIT:
  - Wait for BusRValid. It is only sampled in this state; it is never coincident with the acceptance cycle.
  - BusRValid & BusErr: fault=10 and go to RESP, with no write issued.
  - BusRValid & ~BusErr: latch BusRData and go to WR_REQ.
- WR_REQ:
  - BusWrite=1 with BusWData and BusByteEn held until BusReady=1, then go to RESP.
  - Writes are posted; there is no write response.
- RESP: AmoRespValid=1 for exactly one cycle, then go to IDLE. There is no back-to-back acceptance in RESP.
- Minimum latency: request accepted in cycle 0, AmoRespValid in cycle 4.
- Lane selection:
  - XLEN=64 .W uses the half selected by Adr[2].
  - Operand a = selected memory word/dword; b = AmoSrc[31:0] or AmoSrc.
  - The 32-bit result is replicated into both halves of BusWData; BusByteEn=0x0F or 0xF0 by Adr[2].
  - .D uses BusByteEn=all ones.
- Functions (funct5 -> new value):
  - 00001 SWAP -> b
  - 00000 ADD -> a+b, wrapping modulo the width
  - 00100 XOR, 01100 AND, 01000 OR
  - 10000 MIN / 10100 MAX: signed compare at the operation width
  - 11000 MINU / 11100 MAXU: unsigned compare
  - All other encodings are illegal.
- AmoResult: the original a; .W sign-extended from bit 31. It is 0 on any fault.
- AmoReqValid outside IDLE is ignored (AmoReqReady=0).

Decomposition:
- Shared package (cvw):
  - AMO funct5 localparams.
  - State enum (amostate_t).
  - AmoFault encoding constants.
- One sub-module: amoalu (combinational).
  - Inputs: a, b, funct5, width.
  - Output: new value.
  - Reused by the cache AMO path.

Test Plan:
1. XLEN=64 AMOADD.D at 0x8000_0000, memory 0x7FFF_FFFF_FFFF_FFFF, AmoSrc=1, BusReady always 1, RData one cycle later -> write 0x8000_0000_0000_0000 with ByteEn=0xFF; AmoResult=0x7FFF_FFFF_FFFF_FFFF; RespValid in cycle 4.
2. AMOMIN.W at 0x8000_0004, BusRData=0x0000_0005_xxxx_xxxx, AmoSrc=0xFFFF_FFFF (-1) -> BusWData=0xFFFF_FFFF_FFFF_FFFF, ByteEn=0xF0; AmoResult=0x0000_0000_0000_0005.
3. AMOMAXU.W with memory word 0x8000_0000 -> result 0xFFFF_FFFF_8000_0000 (sign-extended); write data 0x8000_0000 vs AmoSrc 0x1 -> memory unchanged value written.
4. AMOSWAP.W at 0x...02 -> no BusRead/BusWrite; AmoFault=01 one cycle after acceptance+1; funct5=00010 -> AmoFault=11.
5. Read returns BusErr=1 -> no BusWrite ever asserted; AmoFault=10; AmoResult=0.
6. Hold BusReady=0 for 3 cycles in RD_REQ and WR_REQ -> request signals stable throughout; reset asserted in RD_WAIT -> next cycle IDLE, BusRead=0, no AmoRespValid.
